seg_readback_decoder: RTL
=========================

Name: seg_readback_decoder

Overview:
- Reverse path of the ALU result display: watches the 8-bit seven-segment bus (SEG encoding incl. sign bit 7) and recovers the 3-bit two's-complement result.
- Filters glitches with a stability counter and emits each new stable pattern once, on a valid/ready output.
- Flags overflow and illegal patterns.
- Used as a self-check monitor beside the ALU/display logic on the board and in simulation.

Parameters:
- STABLE_CYCLES, 4: consecutive equal samples required before a pattern is accepted (legal range 1..255).
- NBITS_SEG, 8: SEG bus width. Fixed at 8; other values are unsupported.

Ports:
- clk_2  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- seg_in  in  NBITS_SEG  segment pattern under observation
- out_ready  in  1  consumer accepts current output
- out_valid  out  1  decoded result available
- out_value  out  3  decoded two's-complement value
- out_ovf  out  1  pattern was the overflow code
- out_invalid  out  1  pattern matched no legal code
- overrun  out  1  sticky; an accepted pattern was lost
- err_count  out  8  count of accepted illegal patterns (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all outputs 0; seg_q=0, stab_cnt=0, last_seg=0, have_last=0, state=TRACK.
- Every edge: seg_q <= seg_in.
- Stability counter:
  - seg_in != seg_q: stab_cnt <= 0, state <= TRACK.
  - seg_in == seg_q and state == TRACK: stab_cnt increments.
  - Acceptance occurs when stab_cnt == STABLE_CYCLES-1 and seg_in == seg_q; state <= HOLD.
  - HOLD: stab_cnt frozen until seg_in changes.
- Latency:
  - Pattern first sampled at edge k → accepted at edge k+STABLE_CYCLES.
  - out_valid is high after that edge.
- Change-only emission:
  - Accept is discarded (no emit, no count) if have_last and pattern == last_seg.
  - Otherwise: last_seg <= pattern, have_last <= 1, emit.
- Decode (exact 8-bit match):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0xE6→-4 (3'b100), 0xCF→-3, 0xDB→-2, 0x86→-1.
  - 0x80 → out_ovf=1, value=0.
  - Anything else → out_invalid=1, value=0.
  - At most one of ovf/invalid is set.
- Output register:
  - Handshake completes on an edge with out_valid && out_ready; out_valid drops next cycle unless a new emit loads on the same edge.
  - Emit while out_valid=0, or while out_valid && out_ready: register loads, out_valid=1.
  - Emit while out_valid && !out_ready: register keeps old data, overrun <= 1 (sticky until reset), last_seg still updated.
  - out_value/out_ovf/out_invalid stay stable while out_valid && !out_ready.
- Reset mid-operation: immediate clear; a pattern partially counted is forgotten.
- STABLE_CYCLES=1: accept on first edge where seg_in equals seg_q.

Optional Feature:
- Macro: SEG_ERRCNT_EN.
- Defined:
  - err_count increments (saturates at 255) on each emitted invalid pattern, including emits lost to overrun.
  - Cleared by reset.
- Undefined: err_count is tied to 0 and no counter logic is present. All other behaviour is unchanged.

Test Plan:
- Reset then hold seg_in=0x5B, out_ready=1 → out_valid pulses 1 cycle, 4 edges after first sample, out_value=3'b010, ovf=0, invalid=0.
- seg_in=0xE6 held 20 cycles, out_ready=1 → exactly one emit, out_value=3'b100; no repeat while held.
- seg_in alternates 0x06/0x3F every 2 cycles (STABLE_CYCLES=4) → no emit; then 0x86 held → single emit, value=3'b111.
- seg_in=0x80 → emit, out_ovf=1, value=0. Then seg_in=0x12 → emit, out_invalid=1; err_count=1 with SEG_ERRCNT_EN, 0 without.
- out_ready=0; present 0x06 then 0x4F, each stable → first held (value=1), overrun=1. Raise out_ready → value 1 consumed; out_valid=0; overrun stays 1.
- Assert rst_n=0 at stab_cnt=2 mid-count → all outputs 0 immediately. Release with same pattern → full STABLE_CYCLES count restarts, then emit.

Source files
------------

// File: rtl/seg_readback_decoder.sv
// Seven-segment readback monitor: debounces the SEG bus and decodes the 3-bit result.
// Optional saturating illegal-pattern counter enabled by SEG_ERRCNT_EN.
module seg_readback_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NBITS_SEG     = 8
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    input  logic [NBITS_SEG-1:0] seg_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [2:0]           out_value,
    output logic                 out_ovf,
    output logic                 out_invalid,
    output logic                 overrun,
    output logic [7:0]           err_count
);

    typedef enum logic {TRACK, HOLD} state_t;

    localparam logic [7:0] LP_LAST = 8'(STABLE_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NBITS_SEG-1:0]   r_seg_q;
    logic [NBITS_SEG-1:0]   r_last_seg;
    logic                   r_have_last;
    logic [7:0]             r_stab_cnt;
    logic [7:0]             w_cnt_nxt;
    logic                   w_same;
    logic                   w_accept;
    logic                   w_emit;
    logic [2:0]             w_dec_val;
    logic                   w_dec_ovf;
    logic                   w_dec_inv;
    logic                   r_valid;
    logic [2:0]             r_value;
    logic                   r_ovf;
    logic                   r_inv;
    logic                   r_overrun;

    assign w_same   = (seg_in == r_seg_q);
    assign w_accept = w_same && (r_state == TRACK)
                      && (r_stab_cnt == LP_LAST);
    assign w_emit   = w_accept
                      && !(r_have_last && (r_seg_q == r_last_seg));

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TRACK;
            r_seg_q    <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_seg_q    <= seg_in;
            r_stab_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_stab_cnt;
        if (!w_same) begin
            w_state_nxt = TRACK;
            w_cnt_nxt   = '0;
        end else if (r_state == TRACK) begin
            if (w_accept) w_state_nxt = HOLD;
            else          w_cnt_nxt   = r_stab_cnt + 8'd1;
        end
    end

    always_comb begin
        w_dec_val = 3'b000;
        w_dec_ovf = 1'b0;
        w_dec_inv = 1'b0;
        case (r_seg_q)
            8'h3F:   w_dec_val = 3'b000;
            8'h06:   w_dec_val = 3'b001;
            8'h5B:   w_dec_val = 3'b010;
            8'h4F:   w_dec_val = 3'b011;
            8'hE6:   w_dec_val = 3'b100;
            8'hCF:   w_dec_val = 3'b101;
            8'hDB:   w_dec_val = 3'b110;
            8'h86:   w_dec_val = 3'b111;
            8'h80:   w_dec_ovf = 1'b1;
            default: w_dec_inv = 1'b1;
        endcase
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_last_seg  <= '0;
            r_have_last <= 1'b0;
            r_valid     <= 1'b0;
            r_value     <= '0;
            r_ovf       <= 1'b0;
            r_inv       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_emit) begin
                r_last_seg  <= r_seg_q;
                r_have_last <= 1'b1;
            end
            // A stalled consumer keeps its data; the new pattern is dropped.
            if (w_emit && (!r_valid || out_ready)) begin
                r_valid <= 1'b1;
                r_value <= w_dec_val;
                r_ovf   <= w_dec_ovf;
                r_inv   <= w_dec_inv;
            end else if (w_emit) begin
                r_overrun <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SEG_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_emit && w_dec_inv && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = '0;
`endif

    assign out_valid   = r_valid;
    assign out_value   = r_value;
    assign out_ovf     = r_ovf;
    assign out_invalid = r_inv;
    assign overrun     = r_overrun;

endmodule
